// File: rtl/control_sequencer.sv
// Hardwired T0-T5 control unit: fetch/decode/execute/writeback strobes, Moore on state and IR.
// One state per cycle while run_en is high; run_en low freezes state and zeroes every strobe.
module control_sequencer #(
    parameter int OPC_LSB = 27,
    parameter int OPW     = 5
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run_en,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDMuxread,
    output logic        RAMread,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        CSEout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        run,
    output logic        illegal_op,
    output logic [2:0]  tstate
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    state_t         state_q, state_d;
    logic [OPW-1:0] opcode;
    logic           is_alu_r, is_alu_i, is_ldi, is_halt;
    logic [8:0]     alu_sel;   // {ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL}
    logic           unused_ir;

    assign opcode    = IR[OPC_LSB+OPW-1:OPC_LSB];
    assign unused_ir = ^IR;

    always_comb begin
        is_alu_r = 1'b0;
        is_alu_i = 1'b0;
        is_ldi   = 1'b0;
        is_halt  = 1'b0;
        alu_sel  = 9'd0;
        case (opcode)
            OP_ADD:  begin is_alu_r = 1'b1; alu_sel = 9'b100000000; end
            OP_SUB:  begin is_alu_r = 1'b1; alu_sel = 9'b010000000; end
            OP_AND:  begin is_alu_r = 1'b1; alu_sel = 9'b001000000; end
            OP_OR:   begin is_alu_r = 1'b1; alu_sel = 9'b000100000; end
            OP_SHR:  begin is_alu_r = 1'b1; alu_sel = 9'b000010000; end
            OP_SHRA: begin is_alu_r = 1'b1; alu_sel = 9'b000001000; end
            OP_SHL:  begin is_alu_r = 1'b1; alu_sel = 9'b000000100; end
            OP_ROR:  begin is_alu_r = 1'b1; alu_sel = 9'b000000010; end
            OP_ROL:  begin is_alu_r = 1'b1; alu_sel = 9'b000000001; end
            OP_ADDI: begin is_alu_i = 1'b1; alu_sel = 9'b100000000; end
            OP_ANDI: begin is_alu_i = 1'b1; alu_sel = 9'b001000000; end
            OP_ORI:  begin is_alu_i = 1'b1; alu_sel = 9'b000100000; end
            OP_LDI:  begin is_ldi   = 1'b1; alu_sel = 9'b100000000; end
            OP_HALT: is_halt = 1'b1;
            OP_NOP:  ;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (run_en) begin
            case (state_q)
                S_RST:  state_d = S_T0;
                S_T0:   state_d = S_T1;
                S_T1:   state_d = S_T2;
                S_T2:   state_d = S_T3;
                S_T3: begin
                    if (is_alu_r || is_alu_i || is_ldi) state_d = S_T4;
                    else if (is_halt)                   state_d = S_HALT;
                    else                                state_d = S_T0;
                end
                S_T4:   state_d = S_T5;
                S_T5:   state_d = S_T0;
                S_HALT: state_d = S_HALT;
                default: state_d = S_RST;
            endcase
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= S_RST;
        else       state_q <= state_d;
    end

    assign run    = (state_q != S_RST) && (state_q != S_HALT);
    assign tstate = state_q;

    // Strobes decode straight from the state register so a clear kills them in the same cycle.
    always_comb begin
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, IRin} = 9'd0;
        {Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout}     = 10'd0;
        {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL}                       = 9'd0;
        illegal_op = 1'b0;
        if (run_en) begin
            case (state_q)
                S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
                S_T1: begin
                    Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1;
                    RAMread = 1'b1; MDRin = 1'b1;
                end
                S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
                S_T3: begin
                    if (is_alu_r || is_alu_i) begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end else if (is_ldi) begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end else if (!is_halt && opcode != OP_NOP) begin
                        illegal_op = 1'b1;
                    end
                end
                S_T4: begin
                    if (is_alu_r) begin
                        Grc = 1'b1; Rout = 1'b1;
                    end else begin
                        CSEout = 1'b1;
                    end
                    Zlowin = 1'b1;
                    {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL} = alu_sel;
                end
                S_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks ldi/andi/add/nop/illegal/halt, run_en stall and clears.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, run_en;
    logic [31:0] IR;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, IRin;
    logic Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout;
    logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL;
    logic run, illegal_op;
    logic [2:0] tstate;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run_en(run_en), .IR(IR),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .MDMuxread(MDMuxread), .RAMread(RAMread),
        .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .CSEout(CSEout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA),
        .SHL(SHL), .ROR(ROR), .ROL(ROL),
        .run(run), .illegal_op(illegal_op), .tstate(tstate)
    );

    logic [18:0] obs_sb;
    logic [8:0]  obs_alu;
    assign obs_sb  = {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, IRin,
                      Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout};
    assign obs_alu = {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL};

    localparam logic [18:0] B_PCOUT   = 19'b1 << 18;
    localparam logic [18:0] B_PCIN    = 19'b1 << 17;
    localparam logic [18:0] B_INCPC   = 19'b1 << 16;
    localparam logic [18:0] B_MARIN   = 19'b1 << 15;
    localparam logic [18:0] B_MDRIN   = 19'b1 << 14;
    localparam logic [18:0] B_MDROUT  = 19'b1 << 13;
    localparam logic [18:0] B_MDMUX   = 19'b1 << 12;
    localparam logic [18:0] B_RAMRD   = 19'b1 << 11;
    localparam logic [18:0] B_IRIN    = 19'b1 << 10;
    localparam logic [18:0] B_YIN     = 19'b1 << 9;
    localparam logic [18:0] B_ZLOWIN  = 19'b1 << 8;
    localparam logic [18:0] B_ZLOWOUT = 19'b1 << 7;
    localparam logic [18:0] B_CSEOUT  = 19'b1 << 6;
    localparam logic [18:0] B_GRA     = 19'b1 << 5;
    localparam logic [18:0] B_GRB     = 19'b1 << 4;
    localparam logic [18:0] B_GRC     = 19'b1 << 3;
    localparam logic [18:0] B_RIN     = 19'b1 << 2;
    localparam logic [18:0] B_ROUT    = 19'b1 << 1;
    localparam logic [18:0] B_BAOUT   = 19'b1;

    localparam logic [18:0] SB_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
    localparam logic [18:0] SB_T1   = B_ZLOWOUT | B_PCIN | B_MDMUX | B_RAMRD | B_MDRIN;
    localparam logic [18:0] SB_T2   = B_MDROUT | B_IRIN;
    localparam logic [18:0] SB_T3R  = B_GRB | B_ROUT | B_YIN;
    localparam logic [18:0] SB_T3L  = B_GRB | B_BAOUT | B_YIN;
    localparam logic [18:0] SB_T4R  = B_GRC | B_ROUT | B_ZLOWIN;
    localparam logic [18:0] SB_T4I  = B_CSEOUT | B_ZLOWIN;
    localparam logic [18:0] SB_T5   = B_ZLOWOUT | B_GRA | B_RIN;

    localparam logic [8:0] A_NONE = 9'd0;
    localparam logic [8:0] A_ADD  = 9'b100000000;
    localparam logic [8:0] A_AND  = 9'b001000000;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag, input logic [2:0] ts, input logic [18:0] sb,
                         input logic [8:0] al, input logic rn, input logic il);
        cmp({tag, ".tstate"}, 32'(tstate), 32'(ts));
        cmp({tag, ".strobes"}, 32'(obs_sb), 32'(sb));
        cmp({tag, ".alu"}, 32'(obs_alu), 32'(al));
        cmp({tag, ".run"}, 32'(run), 32'(rn));
        cmp({tag, ".illegal_op"}, 32'(illegal_op), 32'(il));
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Entered at a T0 sample point; leaves the bench sampling T3.
    task automatic fetch(input string tag, input logic [31:0] ir);
        IR = ir;
        check({tag, ".T0"}, 3'd1, SB_T0, A_NONE, 1'b1, 1'b0);
        tick();
        check({tag, ".T1"}, 3'd2, SB_T1, A_NONE, 1'b1, 1'b0);
        tick();
        check({tag, ".T2"}, 3'd3, SB_T2, A_NONE, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        clear  = 1'b1;
        run_en = 1'b1;
        IR     = 32'd0;
        #1;
        check("reset_async", 3'd0, 19'd0, A_NONE, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("reset_hold", 3'd0, 19'd0, A_NONE, 1'b0, 1'b0);
        clear = 1'b0;
        tick();

        // ldi R4,0x50
        fetch("ldi", 32'h0A000050);
        check("ldi.T3", 3'd4, SB_T3L, A_NONE, 1'b1, 1'b0);
        tick();
        check("ldi.T4", 3'd5, SB_T4I, A_ADD, 1'b1, 1'b0);
        tick();
        check("ldi.T5", 3'd6, SB_T5, A_NONE, 1'b1, 1'b0);
        tick();

        // andi R3,R4,0x53
        fetch("andi", 32'h69A00053);
        check("andi.T3", 3'd4, SB_T3R, A_NONE, 1'b1, 1'b0);
        tick();
        check("andi.T4", 3'd5, SB_T4I, A_AND, 1'b1, 1'b0);
        tick();
        check("andi.T5", 3'd6, SB_T5, A_NONE, 1'b1, 1'b0);
        tick();

        // add R5,R3,R4
        fetch("add", 32'h1A9A0000);
        check("add.T3", 3'd4, SB_T3R, A_NONE, 1'b1, 1'b0);
        tick();
        check("add.T4", 3'd5, SB_T4R, A_ADD, 1'b1, 1'b0);
        tick();
        check("add.T5", 3'd6, SB_T5, A_NONE, 1'b1, 1'b0);
        tick();

        fetch("nop", 32'hD0000000);
        check("nop.T3", 3'd4, 19'd0, A_NONE, 1'b1, 1'b0);
        tick();

        fetch("illegal", 32'hF8000000);
        check("illegal.T3", 3'd4, 19'd0, A_NONE, 1'b1, 1'b1);
        tick();
        check("illegal.after", 3'd1, SB_T0, A_NONE, 1'b1, 1'b0);

        fetch("halt", 32'hD8000000);
        check("halt.T3", 3'd4, 19'd0, A_NONE, 1'b1, 1'b0);
        tick();
        check("halt.enter", 3'd7, 19'd0, A_NONE, 1'b0, 1'b0);
        repeat (20) tick();
        check("halt.persist", 3'd7, 19'd0, A_NONE, 1'b0, 1'b0);
        clear = 1'b1;
        #1;
        check("halt.clear", 3'd0, 19'd0, A_NONE, 1'b0, 1'b0);
        @(negedge clock);
        clear = 1'b0;
        tick();

        // run_en stall while in T1
        IR = 32'h1A9A0000;
        check("stall.T0", 3'd1, SB_T0, A_NONE, 1'b1, 1'b0);
        tick();
        check("stall.T1", 3'd2, SB_T1, A_NONE, 1'b1, 1'b0);
        run_en = 1'b0;
        #1;
        check("stall.drop", 3'd2, 19'd0, A_NONE, 1'b1, 1'b0);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.hold", 3'd2, 19'd0, A_NONE, 1'b1, 1'b0);
        end
        run_en = 1'b1;
        #1;
        check("stall.resume", 3'd2, SB_T1, A_NONE, 1'b1, 1'b0);
        tick();
        check("stall.T2", 3'd3, SB_T2, A_NONE, 1'b1, 1'b0);
        tick();
        check("stall.T3", 3'd4, SB_T3R, A_NONE, 1'b1, 1'b0);
        tick();
        check("midclr.T4", 3'd5, SB_T4R, A_ADD, 1'b1, 1'b0);

        // clear mid-instruction drops every strobe without waiting for an edge
        clear = 1'b1;
        #1;
        check("midclr.async", 3'd0, 19'd0, A_NONE, 1'b0, 1'b0);
        @(negedge clock);
        clear = 1'b0;
        tick();
        check("midclr.restart", 3'd1, SB_T0, A_NONE, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish within 100000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
